rc4_phase_sequencer: RTL and testbench
======================================

Name: rc4_phase_sequencer

Overview:
- Top-level controller for the RC4 datapath built around the single-port 256x8 S-array RAM.
- Sequences three client FSMs in order: S-array init (s[i]=i), key-scheduling (KSA), and keystream/decrypt (PRGA).
- Owns the RAM port and muxes it to whichever client is active, so clients never contend for it.
- Gives the host a read-only view of the RAM when no phase is running, and a watchdog for hung clients.

Parameters:
- KEY_W, 24, secret key width presented to KSA.
- TIMEOUT_CYCLES, 4096, maximum cycles a phase may run before the error state is entered.
- TMR_W, 13, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: begin a run
- key_in  in  KEY_W  key sampled on an accepted start
- key  out  KEY_W  latched key driven to KSA
- busy  out  1  a phase is in progress
- done  out  1  all phases complete
- error  out  1  watchdog expired
- init_start/ksa_start/prga_start  out  1 each  single-cycle start pulse to each client
- init_done/ksa_done/prga_done  in  1 each  client finished (level; held until the client's next start)
- init_addr/ksa_addr/prga_addr  in  8 each  client RAM address
- init_data/ksa_data/prga_data  in  8 each  client RAM write data
- init_wren/ksa_wren/prga_wren  in  1 each  client write enable
- prga_key_bad  in  1  PRGA found a non-printable plaintext byte; valid with prga_done
- host_addr  in  8  host read address
- mem_addr  out  8  to RAM address
- mem_data  out  8  to RAM data
- mem_wren  out  1  to RAM wren
- RAM q is routed directly to all clients and the host; it does not pass through this block.

Behaviour:
- Reset: state IDLE; key=0, busy=0, done=0, error=0, all *_start=0, timer=0.
- States: IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, DONE, ERR.
- Transitions:
  - IDLE or DONE, start=1 → INIT_GO; key<=key_in; done<=0.
  - X_GO → X_RUN unconditionally; X_start=1 for exactly the X_GO cycle (registered output).
  - INIT_RUN, init_done=1 → KSA_GO.
  - KSA_RUN, ksa_done=1 → PRGA_GO.
  - PRGA_RUN, prga_done=1 → DONE.
- A done level is only sampled in the matching RUN state; the first RUN cycle ignores done, so a stale level from a previous run is never seen.
- start while busy is ignored; no queuing.
- busy=1 in every GO/RUN state. done=1 only in DONE. error=1 only in ERR.
- RAM mux: combinational from the registered state, no added latency.
  - INIT_*: init client; KSA_*: ksa client; PRGA_*: prga client.
  - IDLE/DONE/ERR: mem_addr=host_addr, mem_data=0, mem_wren=0.
  - Inactive clients' wren never reaches the RAM.
- Watchdog: timer cleared in each GO state, increments in RUN. When timer reaches TIMEOUT_CYCLES-1 with done still low → ERR.
- ERR is sticky: mem_wren forced 0, start ignored, exit only via rst.
- Reset mid-phase: returns to IDLE immediately; *_start drops to 0; RAM contents undefined until the next init.

Optional Feature:
- Macro: RC4_CRACK_LOOP_EN.
- Enabled: in PRGA_RUN with prga_done=1 and prga_key_bad=1, key<=key+1 and go to INIT_GO (full restart); the watchdog restarts with that INIT_GO.
  - If key wraps past all-ones to 0 → ERR, with error=1.
  - prga_key_bad=0 → DONE as normal.
- Disabled: prga_key_bad is ignored; PRGA_RUN always goes to DONE; key never changes after latching.

Decomposition:
- Package rc4_pkg holds:
  - typedef phase_state_t (enum of the 9 states);
  - typedef mem_req_t struct {addr[7:0], data[7:0], wren};
  - constants S_DEPTH=256, ADDR_W=8.
- One sub-module: rc4_mem_mux. Purely combinational port select, keyed on the current phase, including host fallback and the ERR wren kill.

Test Plan:
- Normal run: stub clients assert done 300/800/1200 cycles after their start. Check:
  - start pulses are exactly one cycle each, in order init → ksa → prga;
  - busy is high throughout; done=1 after prga_done; key equals key_in=24'h000249.
- Mux isolation: all clients hold wren=1 with distinct addresses (0x11/0x22/0x33). Check:
  - mem_addr follows the active phase only;
  - mem_wren=0 in IDLE/DONE with mem_addr=host_addr=0x7F.
- start pulsed during KSA_RUN → ignored: no extra init_start, key unchanged.
- Watchdog: ksa_done never asserted with TIMEOUT_CYCLES=64 → ERR exactly 64 cycles after KSA_GO. error=1, mem_wren=0, start ignored; rst clears to IDLE.
- Reset asserted mid-INIT_RUN with init_wren=1 → immediate IDLE; mem_wren=0 and all outputs at reset values on the same edge.
- With RC4_CRACK_LOOP_EN, key_in=0, prga_key_bad=1 for the first 3 runs:
  - key steps 0 → 1 → 2 → 3 and init_start fires 4 times; done=1 with key=3.
  - Separately, key_in=24'hFFFFFF with prga_key_bad=1 → ERR.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 phase sequencer and its RAM port mux.
package rc4_pkg;

    localparam int unsigned S_DEPTH = 256;
    localparam int unsigned ADDR_W  = 8;

    typedef enum logic [3:0] {
        StIdle,
        StInitGo,
        StInitRun,
        StKsaGo,
        StKsaRun,
        StPrgaGo,
        StPrgaRun,
        StDone,
        StErr
    } phase_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              wren;
    } mem_req_t;

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational S-array RAM port select: the active phase's client owns the port, otherwise
// the host gets a read-only view.
module rc4_mem_mux
    import rc4_pkg::*;
(
    input  logic [3:0]        i_phase,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic [7:0]        i_init_data,
    input  logic              i_init_wren,
    input  logic [ADDR_W-1:0] i_ksa_addr,
    input  logic [7:0]        i_ksa_data,
    input  logic              i_ksa_wren,
    input  logic [ADDR_W-1:0] i_prga_addr,
    input  logic [7:0]        i_prga_data,
    input  logic              i_prga_wren,
    input  logic [ADDR_W-1:0] i_host_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_mem_wren
);

    mem_req_t w_sel;

    // IDLE, DONE and ERR all fall through to the host, which never writes.
    always_comb begin
        w_sel = '{addr: i_host_addr, data: 8'h00, wren: 1'b0};
        case (phase_state_t'(i_phase))
            StInitGo, StInitRun: w_sel = '{addr: i_init_addr, data: i_init_data, wren: i_init_wren};
            StKsaGo, StKsaRun:   w_sel = '{addr: i_ksa_addr, data: i_ksa_data, wren: i_ksa_wren};
            StPrgaGo, StPrgaRun: w_sel = '{addr: i_prga_addr, data: i_prga_data, wren: i_prga_wren};
            default:             w_sel = '{addr: i_host_addr, data: 8'h00, wren: 1'b0};
        endcase
    end

    assign o_mem_addr = w_sel.addr;
    assign o_mem_data = w_sel.data;
    assign o_mem_wren = w_sel.wren;

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Sequences the RC4 init -> KSA -> PRGA clients, owns the S-array RAM port and runs a per-phase
// watchdog. Define RC4_CRACK_LOOP_EN to retry with key+1 whenever PRGA reports a bad key.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_W          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TMR_W          = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [KEY_W-1:0]  i_key_in,
    output logic [KEY_W-1:0]  o_key,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_init_start,
    output logic              o_ksa_start,
    output logic              o_prga_start,
    input  logic              i_init_done,
    input  logic              i_ksa_done,
    input  logic              i_prga_done,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic [7:0]        i_init_data,
    input  logic              i_init_wren,
    input  logic [ADDR_W-1:0] i_ksa_addr,
    input  logic [7:0]        i_ksa_data,
    input  logic              i_ksa_wren,
    input  logic [ADDR_W-1:0] i_prga_addr,
    input  logic [7:0]        i_prga_data,
    input  logic              i_prga_wren,
    input  logic              i_prga_key_bad,
    input  logic [ADDR_W-1:0] i_host_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_mem_wren
);

    // Checked one cycle early so the timer lands on TIMEOUT_CYCLES-1 as ERR is entered.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

    phase_state_t     r_state, w_state_d;
    logic [KEY_W-1:0] r_key, w_key_d;
    logic [TMR_W-1:0] r_timer, w_timer_d;
    logic             r_busy, r_done, r_error;
    logic             r_init_start, r_ksa_start, r_prga_start;
    logic             w_first_run, w_timeout;

    assign w_first_run = (r_timer == '0);
    assign w_timeout   = (r_timer == TMR_LAST);

`ifndef RC4_CRACK_LOOP_EN
    logic w_unused_key_bad;
    assign w_unused_key_bad = i_prga_key_bad;
`endif

    always_comb begin
        w_state_d = r_state;
        w_key_d   = r_key;
        w_timer_d = r_timer;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_d = StInitGo;
                    w_key_d   = i_key_in;
                end
            end
            StInitGo: begin
                w_state_d = StInitRun;
                w_timer_d = '0;
            end
            StInitRun: begin
                w_timer_d = r_timer + 1'b1;
                if (!w_first_run && i_init_done) w_state_d = StKsaGo;
                else if (w_timeout)              w_state_d = StErr;
            end
            StKsaGo: begin
                w_state_d = StKsaRun;
                w_timer_d = '0;
            end
            StKsaRun: begin
                w_timer_d = r_timer + 1'b1;
                if (!w_first_run && i_ksa_done) w_state_d = StPrgaGo;
                else if (w_timeout)             w_state_d = StErr;
            end
            StPrgaGo: begin
                w_state_d = StPrgaRun;
                w_timer_d = '0;
            end
            StPrgaRun: begin
                w_timer_d = r_timer + 1'b1;
                if (!w_first_run && i_prga_done) begin
`ifdef RC4_CRACK_LOOP_EN
                    if (i_prga_key_bad) begin
                        w_key_d   = r_key + 1'b1;
                        w_state_d = (r_key == '1) ? StErr : StInitGo;
                    end else begin
                        w_state_d = StDone;
                    end
`else
                    w_state_d = StDone;
`endif
                end else if (w_timeout) begin
                    w_state_d = StErr;
                end
            end
            StErr:   w_state_d = StErr;
            default: w_state_d = StErr;
        endcase
    end

    // Status and start pulses are registered from the next state so they align with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_key        <= '0;
            r_timer      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_init_start <= 1'b0;
            r_ksa_start  <= 1'b0;
            r_prga_start <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_key        <= w_key_d;
            r_timer      <= w_timer_d;
            r_busy       <= w_state_d inside {StInitGo, StInitRun, StKsaGo, StKsaRun,
                                              StPrgaGo, StPrgaRun};
            r_done       <= (w_state_d == StDone);
            r_error      <= (w_state_d == StErr);
            r_init_start <= (w_state_d == StInitGo);
            r_ksa_start  <= (w_state_d == StKsaGo);
            r_prga_start <= (w_state_d == StPrgaGo);
        end
    end

    assign o_key        = r_key;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_init_start = r_init_start;
    assign o_ksa_start  = r_ksa_start;
    assign o_prga_start = r_prga_start;

    rc4_mem_mux u_mem_mux (
        .i_phase     (r_state),
        .i_init_addr (i_init_addr),
        .i_init_data (i_init_data),
        .i_init_wren (i_init_wren),
        .i_ksa_addr  (i_ksa_addr),
        .i_ksa_data  (i_ksa_data),
        .i_ksa_wren  (i_ksa_wren),
        .i_prga_addr (i_prga_addr),
        .i_prga_data (i_prga_data),
        .i_prga_wren (i_prga_wren),
        .i_host_addr (i_host_addr),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_mem_wren  (o_mem_wren)
    );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: stub clients with programmable latency, a default instance and a
// short-watchdog instance; RC4_CRACK_LOOP_EN adds the key-retry scenarios.
module tb_rc4_phase_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] key_in;
    logic        init_done, ksa_done, prga_done, key_bad;
    logic [7:0]  init_addr, ksa_addr, prga_addr, init_data, ksa_data, prga_data, host_addr;
    logic        init_wren, ksa_wren, prga_wren;

    logic [23:0] m_key, wd_key;
    logic        m_busy, m_done, m_error, m_init_start, m_ksa_start, m_prga_start;
    logic        wd_busy, wd_done, wd_error, wd_init_start, wd_ksa_start, wd_prga_start;
    logic [7:0]  m_mem_addr, m_mem_data, wd_mem_addr, wd_mem_data;
    logic        m_mem_wren, wd_mem_wren;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_init = 0, n_ksa = 0, n_prga = 0, n_wide = 0, busy_gaps = 0;
    int order[$];
    logic [23:0] keys_at_init[$];
    bit p_init = 0, p_ksa = 0, p_prga = 0, in_run = 0;
    int lat_init = 300, lat_ksa = 800, lat_prga = 1200;
    int bad_runs = 0, prga_runs = 0;
    int c_i = 0, c_k = 0, c_p = 0;
    int t0;

    rc4_phase_sequencer u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_key_in(key_in), .o_key(m_key),
        .o_busy(m_busy), .o_done(m_done), .o_error(m_error), .o_init_start(m_init_start),
        .o_ksa_start(m_ksa_start), .o_prga_start(m_prga_start), .i_init_done(init_done),
        .i_ksa_done(ksa_done), .i_prga_done(prga_done), .i_init_addr(init_addr),
        .i_init_data(init_data), .i_init_wren(init_wren), .i_ksa_addr(ksa_addr),
        .i_ksa_data(ksa_data), .i_ksa_wren(ksa_wren), .i_prga_addr(prga_addr),
        .i_prga_data(prga_data), .i_prga_wren(prga_wren), .i_prga_key_bad(key_bad),
        .i_host_addr(host_addr), .o_mem_addr(m_mem_addr), .o_mem_data(m_mem_data),
        .o_mem_wren(m_mem_wren)
    );

    rc4_phase_sequencer #(.KEY_W(24), .TIMEOUT_CYCLES(64), .TMR_W(13)) u_dut_wd (
        .clk(clk), .rst(rst), .i_start(start), .i_key_in(key_in), .o_key(wd_key),
        .o_busy(wd_busy), .o_done(wd_done), .o_error(wd_error), .o_init_start(wd_init_start),
        .o_ksa_start(wd_ksa_start), .o_prga_start(wd_prga_start), .i_init_done(init_done),
        .i_ksa_done(ksa_done), .i_prga_done(prga_done), .i_init_addr(init_addr),
        .i_init_data(init_data), .i_init_wren(init_wren), .i_ksa_addr(ksa_addr),
        .i_ksa_data(ksa_data), .i_ksa_wren(ksa_wren), .i_prga_addr(prga_addr),
        .i_prga_data(prga_data), .i_prga_wren(prga_wren), .i_prga_key_bad(key_bad),
        .i_host_addr(host_addr), .o_mem_addr(wd_mem_addr), .o_mem_data(wd_mem_data),
        .o_mem_wren(wd_mem_wren)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stub clients: done rises lat cycles after start, held until the next start.
    initial forever begin
        @(negedge clk);
        if (m_init_start) begin
            c_i = lat_init; init_done = 1'b0;
        end else if (c_i > 0) begin
            c_i--; if (c_i == 0) init_done = 1'b1;
        end
        if (m_ksa_start) begin
            c_k = lat_ksa; ksa_done = 1'b0;
        end else if (c_k > 0) begin
            c_k--; if (c_k == 0) ksa_done = 1'b1;
        end
        if (m_prga_start) begin
            c_p = lat_prga; prga_done = 1'b0;
            key_bad = (prga_runs < bad_runs);
            prga_runs++;
        end else if (c_p > 0) begin
            c_p--; if (c_p == 0) prga_done = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init_start) begin
            n_init++; order.push_back(0); keys_at_init.push_back(m_key);
            if (p_init) n_wide++;
        end
        if (m_ksa_start) begin
            n_ksa++; order.push_back(1); if (p_ksa) n_wide++;
        end
        if (m_prga_start) begin
            n_prga++; order.push_back(2); if (p_prga) n_wide++;
        end
        p_init = m_init_start; p_ksa = m_ksa_start; p_prga = m_prga_start;
        if (in_run && !m_busy && !m_done) busy_gaps++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: return m_init_start;
            1: return m_ksa_start;
            2: return m_prga_start;
            3: return m_done;
            4: return wd_ksa_start;
            5: return wd_error;
            default: return m_error;
        endcase
    endfunction

    task automatic wait_evt(input int which, input int budget, input string tag);
        int k = 0;
        while (!sel(which) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, sel(which)}, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_in = '0; key_bad = 1'b0;
        init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
        init_addr = 8'h11; ksa_addr = 8'h22; prga_addr = 8'h33;
        init_data = 8'hA1; ksa_data = 8'hB2; prga_data = 8'hC3;
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
        host_addr = 8'h7F;
        idle(3);
        chk("rst_key", 32'(m_key), 32'd0);
        chk("rst_flags", {28'd0, m_busy, m_done, m_error, m_init_start}, 32'd0);
        chk("rst_starts", {30'd0, m_ksa_start, m_prga_start}, 32'd0);
        chk("rst_mem", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b0, 8'h7F, 8'h00});
        rst = 1'b0;

        // Normal run; without the crack loop a bad-key report must be ignored.
`ifdef RC4_CRACK_LOOP_EN
        bad_runs = 0;
`else
        bad_runs = 1;
`endif
        key_in = 24'h000249;
        pulse_start();
        wait_evt(0, 5, "init_start_seen");
        in_run = 1;
        idle(100);
        chk("mux_init", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b1, 8'h11, 8'hA1});
        wait_evt(1, 400, "ksa_start_seen");
        idle(100);
        chk("mux_ksa", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b1, 8'h22, 8'hB2});
        key_in = 24'h000000 | 24'($urandom_range(24'h1000, 24'hFFFFF));
        pulse_start();
        idle(10);
        chk("busy_start_ignored", 32'(n_init), 32'd1);
        chk("busy_key_kept", 32'(m_key), 32'h000249);
        wait_evt(2, 900, "prga_start_seen");
        idle(100);
        chk("mux_prga", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b1, 8'h33, 8'hC3});
        wait_evt(3, 1300, "done_seen");
        in_run = 0;
        chk("done_busy", {30'd0, m_done, m_busy}, 32'd2);
        chk("done_key", 32'(m_key), 32'h000249);
        chk("pulse_counts", {8'd0, 8'(n_init), 8'(n_ksa), 8'(n_prga)}, 32'h00010101);
        chk("pulse_width", 32'(n_wide), 32'd0);
        chk("busy_gaps", 32'(busy_gaps), 32'd0);
        chk("order_len", 32'(order.size()), 32'd3);
        for (int i = 0; i < order.size() && i < 3; i++) chk("order", 32'(order[i]), 32'(i));
        chk("mux_done", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b0, 8'h7F, 8'h00});
        host_addr = 8'($urandom_range(0, 255));
        #1;
        chk("mux_host_follow", 32'(m_mem_addr), 32'(host_addr));
        host_addr = 8'h7F;

        // Reset mid-INIT_RUN with init_wren high.
        key_in = 24'h0000AB;
        pulse_start();
        wait_evt(0, 5, "rst_test_init_start");
        idle(10);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_mem", {15'd0, m_mem_wren, m_mem_addr, m_mem_data}, {15'd0, 1'b0, 8'h7F, 8'h00});
        chk("midrst_flags", {27'd0, m_busy, m_done, m_error, m_init_start, m_ksa_start}, 32'd0);
        chk("midrst_key", 32'(m_key), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Watchdog on the 64-cycle instance: KSA never finishes.
        lat_init = 20; lat_ksa = 1000000;
        key_in = 24'h00BEEF;
        pulse_start();
        wait_evt(4, 40, "wd_ksa_start_seen");
        t0 = cyc;
        wait_evt(5, 200, "wd_error_seen");
        chk("wd_latency", 32'(cyc - t0), 32'd64);
        chk("wd_state", {29'd0, wd_error, wd_busy, wd_done}, 32'd4);
        chk("wd_mem", {23'd0, wd_mem_wren, wd_mem_addr}, {23'd0, 1'b0, 8'h7F});
        pulse_start();
        idle(5);
        chk("wd_sticky", {29'd0, wd_error, wd_busy, wd_init_start}, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wd_cleared", {29'd0, wd_error, wd_busy, wd_done}, 32'd0);
        lat_ksa = 800;

`ifdef RC4_CRACK_LOOP_EN
        // Key steps until PRGA stops reporting a bad key.
        lat_init = 10; lat_ksa = 20; lat_prga = 30;
        bad_runs = 3; prga_runs = 0; n_init = 0;
        keys_at_init.delete();
        key_in = 24'h000000;
        pulse_start();
        wait_evt(3, 2000, "crack_done_seen");
        chk("crack_inits", 32'(n_init), 32'd4);
        chk("crack_key", 32'(m_key), 32'd3);
        for (int i = 0; i < keys_at_init.size() && i < 4; i++)
            chk("crack_key_step", 32'(keys_at_init[i]), 32'(i));
        bad_runs = 100; prga_runs = 0;
        key_in = 24'hFFFFFF;
        pulse_start();
        wait_evt(6, 500, "crack_wrap_error_seen");
        chk("crack_wrap_state", {29'd0, m_error, m_busy, m_done}, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
